posicao_sprite: RTL

Parametrised successor to the fixed row-placement logic: places a PAT_W-bit pattern into a ROW_W-bit display row at a run-time position held in a register. Movement comes from synchronised, debounced left/right button levels, with hold-to-repeat timing. It sits between the input-conditioning stage and the LED matrix/row driver, and feeds the row driver a registered row word.

---
 rtl/posicao_pkg.sv | 42 ++++
 rtl/posicao_sprite_if.sv | 36 +++
 rtl/posicao_sprite_tecla_repeticao.sv | 77 +++++++
 rtl/posicao_sprite.sv | 102 ++++++++++
 4 files changed

// File: rtl/posicao_pkg.sv
// +---------------------------------------------------------------------------+
// | posicao_pkg : shared types and step helper for the sprite positioner.     |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

package posicao_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } estado_e;

  typedef enum logic [1:0] {
    DIR_NONE  = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_RIGHT = 2'd2
  } dir_e;

  // One step in the given direction; saturates at the ends unless wrap is set.
  function automatic int passo(input int pos, input dir_e dir, input int pos_max,
                               input bit wrap);
    int r;
    r = pos;
    case (dir)
      DIR_LEFT: begin
        if (pos > 0)   r = pos - 1;
        else if (wrap) r = pos_max;
      end
      DIR_RIGHT: begin
        if (pos < pos_max) r = pos + 1;
        else if (wrap)     r = 0;
      end
      default: r = pos;
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/posicao_sprite_if.sv
// +---------------------------------------------------------------------------+
// | posicao_sprite_if : pattern/button/load inputs and row/position outputs.  |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

interface posicao_sprite_if #(
  parameter int ROW_W = 10,
  parameter int PAT_W = 6
);
  localparam int POS_W = $clog2(ROW_W);

  logic [PAT_W-1:0] pattern_i;
  logic             mv_left_i;
  logic             mv_right_i;
  logic             load_pos_i;
  logic [POS_W-1:0] load_val_i;
  logic [ROW_W-1:0] row_o;
  logic [POS_W-1:0] pos_o;
  logic             at_left_o;
  logic             at_right_o;
  logic             moved_o;

  modport master (
    output pattern_i, mv_left_i, mv_right_i, load_pos_i, load_val_i,
    input  row_o, pos_o, at_left_o, at_right_o, moved_o
  );

  modport slave (
    input  pattern_i, mv_left_i, mv_right_i, load_pos_i, load_val_i,
    output row_o, pos_o, at_left_o, at_right_o, moved_o
  );

endinterface

`default_nettype wire

// File: rtl/posicao_sprite_tecla_repeticao.sv
// +---------------------------------------------------------------------------+
// | tecla_repeticao : hold-to-repeat FSM turning a button direction into steps.|
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

module tecla_repeticao
  import posicao_pkg::*;
#(
  parameter int HOLD_CYC   = 4,
  parameter int REPEAT_CYC = 2
) (
  input  wire  clk,
  input  wire  rst_n,
  input  dir_e dir_i,
  input  logic clear_i,
  output logic step_o,
  output dir_e step_dir_o
);

  localparam int CNT_MAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  estado_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  dir_e             dir_q, dir_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dir_q   <= DIR_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dir_d      = dir_q;
    step_o     = 1'b0;
    step_dir_o = dir_i;
    case (state_q)
      IDLE: begin
        if (dir_i != DIR_NONE) begin
          step_o  = 1'b1;
          cnt_d   = CNT_W'(HOLD_CYC - 1);
          dir_d   = dir_i;
          state_d = HOLD;
        end
      end
      HOLD, REPEAT: begin
        // Releasing or switching direction always restarts from IDLE without a step.
        if (dir_i != dir_q) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          step_o  = 1'b1;
          cnt_d   = CNT_W'(REPEAT_CYC - 1);
          state_d = REPEAT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (clear_i) begin
      step_o  = 1'b0;
      state_d = IDLE;
    end
  end

endmodule

`default_nettype wire

// File: rtl/posicao_sprite.sv
// +---------------------------------------------------------------------------+
// | posicao_sprite : places a pattern in a display row at a button-driven pos.|
// | Optional POSICAO_WRAP_EN: circular positions/placement. Rev 1.0           |
// +---------------------------------------------------------------------------+
`default_nettype none

module posicao_sprite
  import posicao_pkg::*;
#(
  parameter int ROW_W      = 10,
  parameter int PAT_W      = 6,
  parameter int INIT_POS   = 2,
  parameter int HOLD_CYC   = 4,
  parameter int REPEAT_CYC = 2
) (
  input wire clk,
  input wire rst_n,
  posicao_sprite_if.slave bus
);

  localparam int POS_W = $clog2(ROW_W);
`ifdef POSICAO_WRAP_EN
  localparam int POS_MAX = ROW_W - 1;
  localparam bit WRAP    = 1'b1;
`else
  localparam int POS_MAX = ROW_W - PAT_W;
  localparam bit WRAP    = 1'b0;
`endif

  logic [POS_W-1:0] pos_q, pos_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             moved_q, moved_d;
  dir_e             w_dir;
  dir_e             w_step_dir;
  logic             w_step;
  logic [POS_W-1:0] w_pos_step;
  logic [ROW_W-1:0] w_pat_ext;

  always_comb begin
    w_dir = DIR_NONE;
    if (bus.mv_left_i && !bus.mv_right_i)      w_dir = DIR_LEFT;
    else if (bus.mv_right_i && !bus.mv_left_i) w_dir = DIR_RIGHT;
  end

  tecla_repeticao #(
    .HOLD_CYC   (HOLD_CYC),
    .REPEAT_CYC (REPEAT_CYC)
  ) u_tecla (
    .clk        (clk),
    .rst_n      (rst_n),
    .dir_i      (w_dir),
    .clear_i    (bus.load_pos_i),
    .step_o     (w_step),
    .step_dir_o (w_step_dir)
  );

  assign w_pos_step = POS_W'(passo(int'(pos_q), w_step_dir, POS_MAX, WRAP));

  always_comb begin
    pos_d   = pos_q;
    moved_d = 1'b0;
    if (bus.load_pos_i) begin
      pos_d = (bus.load_val_i > POS_W'(POS_MAX)) ? POS_W'(POS_MAX) : bus.load_val_i;
    end else if (w_step) begin
      pos_d   = w_pos_step;
      moved_d = (w_pos_step != pos_q);
    end
  end

  assign w_pat_ext = ROW_W'(bus.pattern_i);

  always_comb begin
`ifdef POSICAO_WRAP_EN
    // Rotate left by pos; a zero shift makes the right-shift term vanish.
    row_d = (w_pat_ext << pos_q) |
            (w_pat_ext >> ((POS_W+1)'(ROW_W) - {1'b0, pos_q}));
`else
    row_d = w_pat_ext << pos_q;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q   <= POS_W'(INIT_POS);
      row_q   <= '0;
      moved_q <= 1'b0;
    end else begin
      pos_q   <= pos_d;
      row_q   <= row_d;
      moved_q <= moved_d;
    end
  end

  assign bus.row_o      = row_q;
  assign bus.pos_o      = pos_q;
  assign bus.moved_o    = moved_q;
  assign bus.at_left_o  = (pos_q == '0);
  assign bus.at_right_o = (pos_q == POS_W'(POS_MAX));

endmodule

`default_nettype wire
